lsq_mem_unit: RTL and testbench
===============================

Name: lsq_mem_unit

Overview:
- Parametrised in-order load/store queue plus memory sequencer. Successor to the fixed-depth LD/ST queue and its separate controller.
- Buffers memory ops from the issue queue and snoops NUM_CDB result buses plus the AGU address bus for operands.
- Performs one physical memory access at a time from the queue head, with sub-word alignment.
- Broadcasts load data / store completion on its own result bus.
- Stores touch memory only when the ROB reports them at commit head.

Parameters:
- DEPTH, 8: queue entries; power of 2, >=2.
- ROB_W, 8: ROB tag width.
- NUM_CDB, 5: number of snooped result buses.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  ROB flush_all; squashes every entry.
- enq_valid  in  1  issue queue presents an op.
- enq_ready  out  1  queue can accept (count<DEPTH).
- enq_is_store  in  1  1=store, 0=load.
- enq_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- enq_rob  in  ROB_W  destination ROB tag; also AGU match key.
- enq_data_valid  in  1  store data already available.
- enq_data_tag  in  ROB_W  producer tag of store data.
- enq_data  in  32  store data when enq_data_valid.
- agu_valid  in  1  address broadcast.
- agu_rob  in  ROB_W  tag of op whose address is ready.
- agu_addr  in  32  effective address.
- cdb_valid  in  NUM_CDB  per-bus valid.
- cdb_tag  in  NUM_CDB*ROB_W  packed tags.
- cdb_data  in  NUM_CDB*32  packed data.
- rob_head_tag  in  ROB_W  tag at ROB commit head.
- rob_head_valid  in  1  rob_head_tag is meaningful.
- res_valid  out  1  one-cycle result pulse.
- res_rob  out  ROB_W  tag of completed op.
- res_data  out  32  extended load data; 0 for stores.
- q_empty  out  1  count==0.
- pmem_read  out  1  read request.
- pmem_write  out  1  write request.
- pmem_address  out  32  word-aligned address {addr[31:2],2'b00}.
- pmem_wdata  out  32  store data shifted to its byte lane.
- mem_byte_enable  out  4  byte lanes.
- pmem_rdata  in  32  read data.
- pmem_resp  in  1  access done.

Behaviour:
- Storage: circular buffer; head/tail pointers of $clog2(DEPTH)+1 bits carrying a wrap bit. Full when indices are equal and wrap bits differ; empty when pointers are equal.
- Enqueue: occurs when enq_valid&&enq_ready. At full, enq_ready=0 even if the head retires that cycle.
- Same-cycle capture at enqueue: if any CDB matches enq_data_tag in the enqueue cycle, the value is captured at enqueue. Same rule for agu_rob==enq_rob.
- Snoop: every valid, occupied entry with data_valid=0 captures the first (lowest index) matching CDB. An entry with addr_valid=0 captures agu_addr when agu_rob matches.
- FSM IDLE -> REQ -> RESP -> IDLE; DRAIN also exists.
  - IDLE: head is issuable when occupied && addr_valid && (load || (data_valid && rob_head_valid && rob_head_tag==rob)). Next cycle: REQ, pmem_read/pmem_write registered high.
  - REQ: holds all pmem_* stable until pmem_resp. On resp: load data is latched and extended by funct3/addr[1:0], and the FSM goes to RESP.
  - RESP: res_valid=1 for exactly one cycle; head advances; FSM returns to IDLE. Earliest next issue is the cycle after.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Flush / reset:
  - rst: all entries invalid, pointers 0, FSM IDLE. Outputs: res_valid=0, res_rob=0, res_data=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_byte_enable=0. q_empty=1, enq_ready=1.
  - flush in IDLE/RESP: same as reset, and res_valid is suppressed.
  - flush in REQ: entries/pointers cleared; FSM enters DRAIN, holding the request until pmem_resp, then IDLE with no broadcast. enq_ready=0 while in DRAIN.
  - rst overrides flush and DRAIN.
- Latency: head becomes issuable in cycle N; pmem request is asserted N+1; pmem_resp arrives in cycle M; res_valid M+1.

Optional Feature:
- LSQ_MISALIGN_TRAP_EN defined:
  - Adds output res_misalign (1 bit).
  - A head op with LH/LHU/SH and addr[0]=1, or LW/SW and addr[1:0]!=0, skips memory: IDLE -> RESP directly, with res_valid=1, res_misalign=1, res_data=0.
- Undefined: the port is absent; misaligned low address bits are masked to natural alignment (addr[0] forced to 0 for halfwords, addr[1:0] for words) and the access proceeds normally.

Test Plan:
- LW, enq_rob=3; AGU addr 0x104; pmem_rdata=0xDEADBEEF after 2 cycles -> pmem_address=0x104, mem_byte_enable=4'hF, res_valid one cycle with res_rob=3, res_data=0xDEADBEEF.
- LB addr 0x203, rdata=0x80FFFFFF -> res_data=0xFFFFFF80. LBU same -> 0x00000080.
- SH rob=5, data tag 9 pending; CDB[4] broadcasts tag 9 value 0x1234ABCD; addr 0x302; rob_head_tag=5 -> pmem_write with mem_byte_enable=4'b1100, pmem_wdata[31:16]=0xABCD. No pmem_write before rob_head_tag==5.
- Fill DEPTH=8 entries without AGU -> enq_ready=0, 9th enqueue ignored. Tail wraps correctly after 8 retire/refill cycles, checked via res_rob order.
- flush while in REQ (pmem_read high) -> pmem_read held until pmem_resp, no res_valid, q_empty=1, enq_ready=0 until resp then 1.
- With LSQ_MISALIGN_TRAP_EN, LW addr 0x101 -> no pmem access, res_misalign=1; without it -> pmem_address=0x100 read.

Source files
------------

// File: rtl/lsq_mem_unit.sv
// In-order load/store queue with a single-outstanding memory sequencer.
// Optional LSQ_MISALIGN_TRAP_EN: misaligned head ops complete with res_misalign instead of accessing memory.

module lsq_cdb_match #(
   parameter int NUM_CDB = 5,
   parameter int ROB_W   = 8
) (
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]    cdb_data,
   input  logic [ROB_W-1:0]         tag,
   output logic                     hit,
   output logic [31:0]              data
);
   // Walk from the top so the lowest matching bus wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
         if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == tag) begin
            hit  = 1'b1;
            data = cdb_data[i*32 +: 32];
         end
      end
   end
endmodule

module lsq_mem_unit #(
   parameter int DEPTH   = 8,
   parameter int ROB_W   = 8,
   parameter int NUM_CDB = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic                     enq_is_store,
   input  logic [2:0]               enq_funct3,
   input  logic [ROB_W-1:0]         enq_rob,
   input  logic                     enq_data_valid,
   input  logic [ROB_W-1:0]         enq_data_tag,
   input  logic [31:0]              enq_data,
   input  logic                     agu_valid,
   input  logic [ROB_W-1:0]         agu_rob,
   input  logic [31:0]              agu_addr,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]    cdb_data,
   input  logic [ROB_W-1:0]         rob_head_tag,
   input  logic                     rob_head_valid,
   output logic                     res_valid,
   output logic [ROB_W-1:0]         res_rob,
   output logic [31:0]              res_data,
`ifdef LSQ_MISALIGN_TRAP_EN
   output logic                     res_misalign,
`endif
   output logic                     q_empty,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [31:0]              pmem_address,
   output logic [31:0]              pmem_wdata,
   output logic [3:0]               mem_byte_enable,
   input  logic [31:0]              pmem_rdata,
   input  logic                     pmem_resp
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   typedef struct packed {
      logic             valid;
      logic             is_store;
      logic [2:0]       funct3;
      logic [ROB_W-1:0] rob;
      logic             data_valid;
      logic [ROB_W-1:0] data_tag;
      logic [31:0]      data;
      logic             addr_valid;
      logic [31:0]      addr;
   } ent_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

   ent_t             ent_q [DEPTH];
   ent_t             ent_d [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   state_t           state_q, state_d;
   logic             pmem_read_q, pmem_read_d, pmem_write_q, pmem_write_d;
   logic [31:0]      pmem_address_q, pmem_address_d, pmem_wdata_q, pmem_wdata_d;
   logic [3:0]       be_q, be_d;
   logic             res_valid_q, res_valid_d;
   logic [ROB_W-1:0] res_rob_q, res_rob_d;
   logic [31:0]      res_data_q, res_data_d;
`ifdef LSQ_MISALIGN_TRAP_EN
   logic             res_mis_q, res_mis_d;
   logic             misalign;
`endif

   logic [DEPTH-1:0]       snp_hit;
   logic [DEPTH-1:0][31:0] snp_data;
   logic                   enq_hit;
   logic [31:0]            enq_hit_data;

   for (genvar g = 0; g < DEPTH; g++) begin : g_snp
      lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_snp (
         .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
         .tag(ent_q[g].data_tag), .hit(snp_hit[g]), .data(snp_data[g])
      );
   end

   lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_enq_snp (
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .tag(enq_data_tag), .hit(enq_hit), .data(enq_hit_data)
   );

   logic [IW-1:0] head_idx, tail_idx;
   logic          full;
   ent_t          hd;
   logic [31:0]   al_addr, hd_wdata, rd_shift, ld_ext;
   logic [3:0]    hd_be;
   logic          issuable;

   assign head_idx  = head_q[IW-1:0];
   assign tail_idx  = tail_q[IW-1:0];
   assign full      = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
   assign q_empty   = (head_q == tail_q);
   assign enq_ready = !full && (state_q != S_DRAIN);

   always_comb begin : head_decode
      hd      = ent_q[head_idx];
      al_addr = hd.addr;
      if (hd.funct3[1:0] == 2'b01) al_addr[0] = 1'b0;
      else if (hd.funct3[1])       al_addr[1:0] = 2'b00;
      case (hd.funct3[1:0])
         2'b00: begin
            hd_be    = 4'b0001 << al_addr[1:0];
            hd_wdata = {24'b0, hd.data[7:0]} << {al_addr[1:0], 3'b000};
         end
         2'b01: begin
            hd_be    = 4'b0011 << {al_addr[1], 1'b0};
            hd_wdata = {16'b0, hd.data[15:0]} << {al_addr[1], 4'b0000};
         end
         default: begin
            hd_be    = 4'b1111;
            hd_wdata = hd.data;
         end
      endcase
      if (!hd.is_store) begin
         hd_be    = 4'b1111;
         hd_wdata = '0;
      end
      // Halfword offsets are already even, so one byte-granular shift serves both sizes.
      rd_shift = pmem_rdata >> {al_addr[1:0], 3'b000};
      case (hd.funct3[1:0])
         2'b00:   ld_ext = hd.funct3[2] ? {24'b0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_ext = hd.funct3[2] ? {16'b0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ld_ext = pmem_rdata;
      endcase
      issuable = hd.valid && hd.addr_valid &&
                 (!hd.is_store || (hd.data_valid && rob_head_valid && rob_head_tag == hd.rob));
`ifdef LSQ_MISALIGN_TRAP_EN
      misalign = ((hd.funct3[1:0] == 2'b01) && hd.addr[0]) ||
                 (hd.funct3[1] && (hd.addr[1:0] != 2'b00));
`endif
   end

   ent_t nw;

   always_comb begin : next_state
      ent_d          = ent_q;
      head_d         = head_q;
      tail_d         = tail_q;
      state_d        = state_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      be_d           = be_q;
      res_valid_d    = 1'b0;
      res_rob_d      = res_rob_q;
      res_data_d     = res_data_q;
`ifdef LSQ_MISALIGN_TRAP_EN
      res_mis_d      = res_mis_q;
`endif
      nw             = '0;

      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid) begin
            if (!ent_q[i].data_valid && snp_hit[i]) begin
               ent_d[i].data_valid = 1'b1;
               ent_d[i].data       = snp_data[i];
            end
            if (!ent_q[i].addr_valid && agu_valid && agu_rob == ent_q[i].rob) begin
               ent_d[i].addr_valid = 1'b1;
               ent_d[i].addr       = agu_addr;
            end
         end
      end

      if (enq_valid && enq_ready) begin
         nw.valid      = 1'b1;
         nw.is_store   = enq_is_store;
         nw.funct3     = enq_funct3;
         nw.rob        = enq_rob;
         nw.data_tag   = enq_data_tag;
         nw.data_valid = enq_data_valid || enq_hit;
         nw.data       = enq_data_valid ? enq_data : enq_hit_data;
         nw.addr_valid = agu_valid && (agu_rob == enq_rob);
         nw.addr       = agu_addr;
         ent_d[tail_idx] = nw;
         tail_d          = tail_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (issuable) begin
               res_rob_d = hd.rob;
`ifdef LSQ_MISALIGN_TRAP_EN
               res_mis_d = misalign;
               if (misalign) begin
                  state_d     = S_RESP;
                  res_valid_d = 1'b1;
                  res_data_d  = '0;
               end else
`endif
               begin
                  state_d        = S_REQ;
                  pmem_read_d    = !hd.is_store;
                  pmem_write_d   = hd.is_store;
                  pmem_address_d = {al_addr[31:2], 2'b00};
                  pmem_wdata_d   = hd_wdata;
                  be_d           = hd_be;
               end
            end
         end
         S_REQ: begin
            if (pmem_resp) begin
               state_d      = S_RESP;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               res_valid_d  = 1'b1;
               res_rob_d    = hd.rob;
               res_data_d   = hd.is_store ? 32'b0 : ld_ext;
            end
         end
         S_RESP: begin
            ent_d[head_idx].valid = 1'b0;
            head_d  = head_q + PW'(1);
            state_d = S_IDLE;
         end
         default: begin
            if (pmem_resp) begin
               state_d      = S_IDLE;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
            end
         end
      endcase

      // A flush mid-access must keep the request up until memory answers.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
         head_d      = '0;
         tail_d      = '0;
         res_valid_d = 1'b0;
         res_rob_d   = '0;
         res_data_d  = '0;
`ifdef LSQ_MISALIGN_TRAP_EN
         res_mis_d   = 1'b0;
`endif
         if (state_q == S_REQ) begin
            state_d = pmem_resp ? S_IDLE : S_DRAIN;
         end else if (state_q != S_DRAIN) begin
            state_d        = S_IDLE;
            pmem_read_d    = 1'b0;
            pmem_write_d   = 1'b0;
            pmem_address_d = '0;
            pmem_wdata_d   = '0;
            be_d           = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         state_q        <= S_IDLE;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         be_q           <= '0;
         res_valid_q    <= 1'b0;
         res_rob_q      <= '0;
         res_data_q     <= '0;
`ifdef LSQ_MISALIGN_TRAP_EN
         res_mis_q      <= 1'b0;
`endif
      end else begin
         ent_q          <= ent_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         state_q        <= state_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
         be_q           <= be_d;
         res_valid_q    <= res_valid_d;
         res_rob_q      <= res_rob_d;
         res_data_q     <= res_data_d;
`ifdef LSQ_MISALIGN_TRAP_EN
         res_mis_q      <= res_mis_d;
`endif
      end
   end

   assign res_valid       = res_valid_q && !flush;
   assign res_rob         = res_rob_q;
   assign res_data        = res_data_q;
`ifdef LSQ_MISALIGN_TRAP_EN
   assign res_misalign    = res_mis_q;
`endif
   assign pmem_read       = pmem_read_q;
   assign pmem_write      = pmem_write_q;
   assign pmem_address    = pmem_address_q;
   assign pmem_wdata      = pmem_wdata_q;
   assign mem_byte_enable = be_q;
endmodule

// File: tb/tb_lsq_mem_unit.sv
// Directed bench for lsq_mem_unit: scoreboard of expected results plus a simple memory responder.
module tb_lsq_mem_unit;
   localparam int DEPTH = 8, ROB_W = 8, NUM_CDB = 5, MEM_LAT = 1;

   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic enq_valid = 1'b0, enq_ready, enq_is_store = 1'b0, enq_data_valid = 1'b0;
   logic [2:0] enq_funct3 = '0;
   logic [ROB_W-1:0] enq_rob = '0, enq_data_tag = '0, agu_rob = '0, rob_head_tag = '0, res_rob;
   logic [31:0] enq_data = '0, agu_addr = '0, res_data, pmem_address, pmem_wdata, pmem_rdata;
   logic agu_valid = 1'b0, rob_head_valid = 1'b0, res_valid, q_empty, pmem_read, pmem_write, pmem_resp;
   logic [NUM_CDB-1:0] cdb_valid = '0;
   logic [NUM_CDB*ROB_W-1:0] cdb_tag = '0;
   logic [NUM_CDB*32-1:0] cdb_data = '0;
   logic [3:0] mem_byte_enable;
`ifdef LSQ_MISALIGN_TRAP_EN
   logic res_misalign;
`endif

   lsq_mem_unit #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_is_store(enq_is_store), .enq_funct3(enq_funct3), .enq_rob(enq_rob),
      .enq_data_valid(enq_data_valid), .enq_data_tag(enq_data_tag), .enq_data(enq_data),
      .agu_valid(agu_valid), .agu_rob(agu_rob), .agu_addr(agu_addr),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rob_head_tag(rob_head_tag), .rob_head_valid(rob_head_valid),
      .res_valid(res_valid), .res_rob(res_rob), .res_data(res_data),
`ifdef LSQ_MISALIGN_TRAP_EN
      .res_misalign(res_misalign),
`endif
      .q_empty(q_empty), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .mem_byte_enable(mem_byte_enable),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory responder
   logic mem_auto = 1'b1, man_resp = 1'b0, auto_resp = 1'b0, was_req = 1'b0;
   logic [31:0] mem_rdata = '0, last_addr = '0, last_wdata = '0;
   logic [3:0] last_be = '0;
   int wait_cnt = 0, acc_cnt = 0, wr_cnt = 0;
   assign pmem_rdata = mem_rdata;
   assign pmem_resp  = mem_auto ? auto_resp : man_resp;

   always @(negedge clk) begin
      if ((pmem_read || pmem_write) && !was_req) begin
         acc_cnt++;
         if (pmem_write) wr_cnt++;
         last_addr  = pmem_address;
         last_wdata = pmem_wdata;
         last_be    = mem_byte_enable;
      end
      was_req = pmem_read || pmem_write;
      auto_resp = 1'b0;
      if (was_req) begin
         if (wait_cnt == MEM_LAT) begin
            auto_resp = 1'b1;
            wait_cnt  = 0;
         end else wait_cnt++;
      end else wait_cnt = 0;
   end

   // Scoreboard
   typedef struct {
      logic [ROB_W-1:0] rob;
      logic [31:0]      data;
      logic             mis;
   } exp_t;
   exp_t sb[$];
   int res_cnt = 0;
   logic prev_res = 1'b0;

   task automatic push(input logic [ROB_W-1:0] rob, input logic [31:0] data, input logic mis);
      exp_t e;
      e.rob = rob; e.data = data; e.mis = mis;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && res_valid) begin
         res_cnt++;
         chk("res_pulse_width", 32'(prev_res), 32'd0);
         if (sb.size() == 0) chk("res_unexpected", 32'(res_rob), 32'hFFFF_FFFF);
         else begin
            e = sb.pop_front();
            chk("res_rob", 32'(res_rob), 32'(e.rob));
            chk("res_data", res_data, e.data);
`ifdef LSQ_MISALIGN_TRAP_EN
            chk("res_misalign", 32'(res_misalign), 32'(e.mis));
`endif
         end
      end
      prev_res = res_valid;
   end

   task automatic enq_op(input logic st, input logic [2:0] f3, input logic [ROB_W-1:0] rob,
                         input logic dv, input logic [ROB_W-1:0] dtag, input logic [31:0] d,
                         input logic av, input logic [31:0] addr);
      int b = 0;
      enq_valid = 1'b1; enq_is_store = st; enq_funct3 = f3; enq_rob = rob;
      enq_data_valid = dv; enq_data_tag = dtag; enq_data = d;
      if (av) begin agu_valid = 1'b1; agu_rob = rob; agu_addr = addr; end
      while (!enq_ready && b < 200) begin @(negedge clk); b++; end
      if (!enq_ready) chk("enq_timeout", 32'(enq_ready), 32'd1);
      @(negedge clk);
      enq_valid = 1'b0; agu_valid = 1'b0;
   endtask

   task automatic agu_bc(input logic [ROB_W-1:0] rob, input logic [31:0] addr);
      agu_valid = 1'b1; agu_rob = rob; agu_addr = addr;
      @(negedge clk);
      agu_valid = 1'b0;
   endtask

   task automatic wait_res(input int target);
      int b = 0;
      while (res_cnt < target && b < 400) begin @(negedge clk); b++; end
      @(negedge clk);
      chk("res_count", 32'(res_cnt), 32'(target));
   endtask

   int w0, r0, a0, base, b;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_rob", 32'(res_rob), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_pmem_rw", {30'b0, pmem_read, pmem_write}, 32'd0);
      chk("rst_pmem_addr", pmem_address, 32'd0);
      chk("rst_pmem_wdata", pmem_wdata, 32'd0);
      chk("rst_be", 32'(mem_byte_enable), 32'd0);
      chk("rst_q_empty", 32'(q_empty), 32'd1);
      chk("rst_enq_ready", 32'(enq_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // LW with address arriving after enqueue; check issue latency
      mem_rdata = 32'hDEAD_BEEF;
      push(8'd3, 32'hDEAD_BEEF, 1'b0);
      enq_op(1'b0, 3'b010, 8'd3, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
      agu_bc(8'd3, 32'h104);
      chk("lw_no_early_read", 32'(pmem_read), 32'd0);
      @(negedge clk);
      chk("lw_read", 32'(pmem_read), 32'd1);
      chk("lw_addr", pmem_address, 32'h104);
      chk("lw_be", 32'(mem_byte_enable), 32'hF);
      wait_res(1);

      // Sub-word loads with same-cycle AGU capture
      mem_rdata = 32'h80FF_FFFF;
      push(8'd7, 32'hFFFF_FF80, 1'b0);
      enq_op(1'b0, 3'b000, 8'd7, 1'b0, 8'd0, 32'd0, 1'b1, 32'h203);
      push(8'd8, 32'h0000_0080, 1'b0);
      enq_op(1'b0, 3'b100, 8'd8, 1'b0, 8'd0, 32'd0, 1'b1, 32'h203);
      wait_res(3);
      mem_rdata = 32'h8001_F00D;
      push(8'd11, 32'hFFFF_8001, 1'b0);
      enq_op(1'b0, 3'b001, 8'd11, 1'b0, 8'd0, 32'd0, 1'b1, 32'h202);
      push(8'd12, 32'h0000_F00D, 1'b0);
      enq_op(1'b0, 3'b101, 8'd12, 1'b0, 8'd0, 32'd0, 1'b1, 32'h200);
      wait_res(5);

      // SH: data from CDB[4], held until ROB head
      rob_head_valid = 1'b1; rob_head_tag = 8'd4;
      w0 = wr_cnt;
      enq_op(1'b1, 3'b001, 8'd5, 1'b0, 8'd9, 32'd0, 1'b1, 32'h302);
      repeat (4) @(negedge clk);
      chk("sh_no_write_wo_data", 32'(wr_cnt), 32'(w0));
      cdb_valid = 5'b10000; cdb_tag[4*ROB_W +: ROB_W] = 8'd9; cdb_data[4*32 +: 32] = 32'h1234_ABCD;
      @(negedge clk);
      cdb_valid = '0;
      repeat (4) @(negedge clk);
      chk("sh_no_write_wo_commit", 32'(wr_cnt), 32'(w0));
      push(8'd5, 32'd0, 1'b0);
      rob_head_tag = 8'd5;
      wait_res(6);
      chk("sh_write_count", 32'(wr_cnt), 32'(w0 + 1));
      chk("sh_be", 32'(last_be), 32'b1100);
      chk("sh_wdata_hi", 32'(last_wdata[31:16]), 32'hABCD);
      chk("sh_addr", last_addr, 32'h300);

      // SB: two CDBs hit the same tag; lowest bus wins
      rob_head_tag = 8'd6;
      enq_op(1'b1, 3'b000, 8'd6, 1'b0, 8'd10, 32'd0, 1'b1, 32'h201);
      cdb_valid = 5'b10100;
      cdb_tag[2*ROB_W +: ROB_W] = 8'd10; cdb_data[2*32 +: 32] = 32'h0000_00A5;
      cdb_tag[4*ROB_W +: ROB_W] = 8'd10; cdb_data[4*32 +: 32] = 32'h0000_005A;
      push(8'd6, 32'd0, 1'b0);
      @(negedge clk);
      cdb_valid = '0;
      wait_res(7);
      chk("sb_be", 32'(last_be), 32'b0010);
      chk("sb_wdata", last_wdata, 32'h0000_A500);

      // SW: store data captured from CDB in the enqueue cycle
      rob_head_tag = 8'd13;
      cdb_valid = 5'b00001; cdb_tag[0 +: ROB_W] = 8'd12; cdb_data[0 +: 32] = 32'hA5A5_5A5A;
      push(8'd13, 32'd0, 1'b0);
      enq_op(1'b1, 3'b010, 8'd13, 1'b0, 8'd12, 32'd0, 1'b1, 32'h500);
      cdb_valid = '0;
      wait_res(8);
      chk("sw_wdata", last_wdata, 32'hA5A5_5A5A);
      chk("sw_be", 32'(last_be), 32'hF);
      rob_head_valid = 1'b0;

      // Fill to full, reject a 9th op, then retire/refill through a wrap
      mem_rdata = 32'h1122_3344;
      for (int i = 0; i < DEPTH; i++)
         enq_op(1'b0, 3'b010, ROB_W'(20 + i), 1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
      chk("full_enq_ready", 32'(enq_ready), 32'd0);
      chk("full_q_empty", 32'(q_empty), 32'd0);
      enq_valid = 1'b1; enq_is_store = 1'b0; enq_funct3 = 3'b010; enq_rob = 8'd99;
      agu_valid = 1'b1; agu_rob = 8'd99; agu_addr = 32'h0;
      @(negedge clk);
      enq_valid = 1'b0; agu_valid = 1'b0;
      chk("full_still_full", 32'(enq_ready), 32'd0);
      base = res_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         push(ROB_W'(20 + i), 32'h1122_3344, 1'b0);
         agu_bc(ROB_W'(20 + i), 32'h600 + 32'(4 * i));
      end
      for (int i = 0; i < DEPTH; i++) begin
         push(ROB_W'(40 + i), 32'h1122_3344, 1'b0);
         enq_op(1'b0, 3'b010, ROB_W'(40 + i), 1'b0, 8'd0, 32'd0, 1'b1, 32'h700);
      end
      wait_res(base + 2 * DEPTH);
      chk("wrap_q_empty", 32'(q_empty), 32'd1);

      // Flush while a read is outstanding
      mem_auto = 1'b0; man_resp = 1'b0;
      r0 = res_cnt;
      enq_op(1'b0, 3'b010, 8'd60, 1'b0, 8'd0, 32'd0, 1'b1, 32'h800);
      b = 0;
      while (!pmem_read && b < 20) begin @(negedge clk); b++; end
      chk("flush_req_seen", 32'(pmem_read), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("drain_read_held", 32'(pmem_read), 32'd1);
      chk("drain_addr_held", pmem_address, 32'h800);
      chk("drain_q_empty", 32'(q_empty), 32'd1);
      chk("drain_enq_ready", 32'(enq_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("drain_read_held2", 32'(pmem_read), 32'd1);
      chk("drain_enq_ready2", 32'(enq_ready), 32'd0);
      man_resp = 1'b1;
      @(negedge clk);
      man_resp = 1'b0;
      chk("drain_done_read", 32'(pmem_read), 32'd0);
      chk("drain_done_ready", 32'(enq_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("drain_no_result", 32'(res_cnt), 32'(r0));

      // Flush in IDLE squashes a pending op
      mem_auto = 1'b1;
      enq_op(1'b0, 3'b010, 8'd61, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
      chk("idle_flush_pre", 32'(q_empty), 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("idle_flush_empty", 32'(q_empty), 32'd1);
      a0 = acc_cnt;
      agu_bc(8'd61, 32'h900);
      repeat (4) @(negedge clk);
      chk("idle_flush_no_access", 32'(acc_cnt), 32'(a0));

      // Misaligned word load
      mem_rdata = 32'hCAFE_F00D;
      a0 = acc_cnt;
`ifdef LSQ_MISALIGN_TRAP_EN
      push(8'd70, 32'd0, 1'b1);
`else
      push(8'd70, 32'hCAFE_F00D, 1'b0);
`endif
      enq_op(1'b0, 3'b010, 8'd70, 1'b0, 8'd0, 32'd0, 1'b1, 32'h101);
      wait_res(r0 + 1);
`ifdef LSQ_MISALIGN_TRAP_EN
      chk("mis_no_access", 32'(acc_cnt), 32'(a0));
`else
      chk("mis_access", 32'(acc_cnt), 32'(a0 + 1));
      chk("mis_addr", last_addr, 32'h100);
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
